imem_loader: RTL and testbench
==============================

# imem_loader

Loads a program into the writable 64×32 instruction memory from a byte stream before the LEGv8 core runs. It holds the core in reset while loading. It assembles little-endian bytes into 32-bit instruction words, writes them at consecutive addresses from 0, and zero-fills the unused addresses. It checks an XOR checksum and releases the core only on a clean load. It sits between the external program port and the write side of imem; the core's fetch side reads the same array.

## Interface

Parameters:
- N, 32, instruction word width (must be 32: four bytes per word)
- ADDR_W, 6, imem address width; depth = 2**ADDR_W = 64

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a load; sampled in IDLE and DONE only
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader can accept a byte
- we  out  1  imem write enable, one-cycle pulse per word
- waddr  out  ADDR_W  imem write address
- wdata  out  N  imem write data
- cpu_hold  out  1  holds the core in reset while high
- done  out  1  load sequence finished
- err  out  1  load failed (bad count or checksum)

## Operation

- **Reset values** (reset low at a rising edge): state=IDLE, byte_ready=0, we=0, waddr=0, wdata=0, cpu_hold=1, done=0, err=0.
  - Partial word, checksum and word counter are cleared.
  - imem contents are not touched.
- **Transfer rule:** a byte moves on a rising edge where byte_valid && byte_ready.
  - byte_valid may drop at any time; gaps stall the loader.
  - byte_ready is high only in COUNT, DATA and CSUM.
- **Stream format:** count byte C (number of words), then 4·C payload bytes (LSB first), then one checksum byte.
  - Checksum = XOR of all payload bytes; the count byte is excluded.
- **States:**
  - IDLE: start=1 → COUNT.
  - COUNT: on transfer, latch C.
    - C>64: err=1, next DONE (no writes).
    - C=0: next CSUM.
    - Otherwise: next DATA.
  - DATA: shift bytes into the assembly register and XOR each into the checksum.
    - On the 4th byte of a word, the word is copied to wdata. we=1 in the next cycle with waddr = word index (0..C-1).
    - Byte acceptance continues without stall during that write cycle.
    - After the 4th byte of word C-1 → CSUM.
  - CSUM: on transfer, compare the byte with the checksum; mismatch sets err=1. Next: FILL if C<64, else DONE.
  - FILL: write wdata=0 at addresses C..63, one per cycle, we high continuously. After the write to 63 → DONE.
    - FILL runs even when err=1, so memory is deterministic.
  - DONE: done=1; cpu_hold=err (core released only if err=0).
    - start=1 → COUNT: clear done, err, counters; cpu_hold=1.
- start is ignored in COUNT, DATA, CSUM and FILL.
- **Reset mid-load:** returns to IDLE with reset values; the next load starts from address 0.

## Timing

- start sampled in IDLE → byte_ready=1 on the next cycle.
- 4th byte of a word accepted at edge k → we=1, waddr, wdata valid during cycle k+1 (registered outputs); imem captures at edge k+1.
  - Last word and checksum byte may be accepted back-to-back; the last write still occurs at k+1.
- Checksum byte accepted at edge k:
  - FILL writes start in cycle k+1 and take 64−C cycles.
  - If C=64, done=1 in cycle k+1.
- FILL write to address 63 in cycle m → done=1 in cycle m+1.
- C>64 accepted at edge k → done=1, err=1 in cycle k+1.
- Minimum load time with no gaps: 1 + 4C + 1 transfer cycles + (64−C) fill cycles + 1.
- waddr holds its last value when we=0; wdata holds its last value.

## Test plan

- **Clean load, C=2:** reset, start, stream 02 01 00 00 F8 1F 00 00 B4 52.
  - Writes 0xF8000001 @0, then 0xB400001F @1.
  - Then 62 consecutive zero writes @2..63.
  - Then done=1, err=0, cpu_hold=0.
- **Bad checksum:** same stream with the last byte 0x53.
  - Identical writes, including the fill.
  - Ends with done=1, err=1, cpu_hold=1.
- **Bad count 0x41:** no we pulses; done=1, err=1 one cycle after the transfer; byte_ready=0.
- **Empty program:** stream 00 00.
  - Exactly 64 zero writes @0..63, then done=1, err=0.
- **Reset mid-word:** assert reset after 2 payload bytes of word 0.
  - All outputs return to their reset values.
  - A new start plus the clean C=2 stream gives the same result as the first scenario.
- **Full program with backpressure:** C=64 with byte_valid deasserted on random cycles.
  - 64 writes with correct data at @0..63 and no fill writes.
  - done=1 one cycle after the checksum byte.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Groups the program-port byte stream, the imem write port and the
// load status of the instruction-memory loader.
//   start       begin a load (honoured only while the loader is idle or done)
//   byte_in     stream data byte
//   byte_valid  byte_in valid
//   byte_ready  loader can accept a byte
//   we          imem write enable, one-cycle pulse per word
//   waddr       imem write address
//   wdata       imem write data
//   cpu_hold    holds the core in reset while high
//   done        load sequence finished
//   err         load failed (bad count or checksum)
// master = program source / status observer, slave = the loader.
interface imem_loader_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) ();
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [N-1:0]      wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, we, waddr, wdata, cpu_hold, done, err
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, we, waddr, wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
// Loads a program into the 2**ADDR_W x N instruction memory from a byte
// stream: count byte C, 4*C little-endian payload bytes, one XOR checksum
// byte over the payload. Words go to addresses 0..C-1, the rest of memory
// is zero-filled, and the core is released (cpu_hold low) only after a
// load with a valid count and matching checksum.
// Ports:
//   clk    system clock, all logic on the rising edge
//   reset  synchronous, active-low reset
//   bus    imem_loader_if slave: byte stream in, imem write port and
//          status (cpu_hold, done, err) out
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;   // count must hold DEPTH itself
    localparam int LANES = N / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CSUM,
        S_FILL,
        S_DONE
    } state_t;

    state_t                     state_reg, state_next;
    logic [CW-1:0]              count_reg, count_next;
    logic [1:0]                 byte_idx_reg, byte_idx_next;
    logic [ADDR_W-1:0]          word_idx_reg, word_idx_next;
    logic [LANES-2:0][7:0]      lane_reg, lane_next;
    logic [7:0]                 csum_reg, csum_next;
    logic                       we_reg, we_next;
    logic [ADDR_W-1:0]          waddr_reg, waddr_next;
    logic [N-1:0]               wdata_reg, wdata_next;
    logic                       cpu_hold_reg, cpu_hold_next;
    logic                       done_reg, done_next;
    logic                       err_reg, err_next;

    logic                       byte_ready_int;
    logic                       xfer;
    logic                       csum_bad;
    logic [N-1:0]               word_full;

    assign byte_ready_int = (state_reg == S_COUNT) || (state_reg == S_DATA) ||
                            (state_reg == S_CSUM);
    assign xfer           = bus.byte_valid && byte_ready_int;
    assign csum_bad       = (bus.byte_in != csum_reg);

    // The completed word is the three buffered lanes plus the byte arriving
    // now, so the write can be issued on the very edge the 4th byte lands.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi == LANES - 1) begin : g_top
                assign word_full[8*gi +: 8] = bus.byte_in;
            end else begin : g_buf
                assign word_full[8*gi +: 8] = lane_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            byte_idx_reg <= '0;
            word_idx_reg <= '0;
            lane_reg     <= '0;
            csum_reg     <= '0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            cpu_hold_reg <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            byte_idx_reg <= byte_idx_next;
            word_idx_reg <= word_idx_next;
            lane_reg     <= lane_next;
            csum_reg     <= csum_next;
            we_reg       <= we_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            cpu_hold_reg <= cpu_hold_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        byte_idx_next = byte_idx_reg;
        word_idx_next = word_idx_reg;
        lane_next     = lane_reg;
        csum_next     = csum_reg;
        we_next       = 1'b0;          // write enable is a pulse by default
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;
        cpu_hold_next = cpu_hold_reg;
        done_next     = done_reg;
        err_next      = err_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_COUNT;
                end
            end

            S_COUNT: begin
                if (xfer) begin
                    csum_next     = '0;
                    byte_idx_next = '0;
                    word_idx_next = '0;
                    if (int'(bus.byte_in) > DEPTH) begin
                        // Oversized program: refuse it outright, memory untouched.
                        err_next      = 1'b1;
                        done_next     = 1'b1;
                        cpu_hold_next = 1'b1;
                        state_next    = S_DONE;
                    end else begin
                        count_next = CW'(bus.byte_in);
                        state_next = (bus.byte_in == 8'd0) ? S_CSUM : S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    csum_next = csum_reg ^ bus.byte_in;
                    if (byte_idx_reg == 2'(LANES - 1)) begin
                        wdata_next    = word_full;
                        we_next       = 1'b1;
                        waddr_next    = word_idx_reg;
                        word_idx_next = word_idx_reg + ADDR_W'(1);
                        byte_idx_next = '0;
                        if ({1'b0, word_idx_reg} == count_reg - CW'(1)) begin
                            state_next = S_CSUM;
                        end
                    end else begin
                        lane_next[byte_idx_reg] = bus.byte_in;
                        byte_idx_next           = byte_idx_reg + 2'd1;
                    end
                end
            end

            S_CSUM: begin
                if (xfer) begin
                    err_next = csum_bad;
                    if (count_reg < CW'(DEPTH)) begin
                        // First fill write goes out on the next cycle at address C.
                        state_next = S_FILL;
                        we_next    = 1'b1;
                        waddr_next = count_reg[ADDR_W-1:0];
                        wdata_next = '0;
                    end else begin
                        state_next    = S_DONE;
                        done_next     = 1'b1;
                        cpu_hold_next = csum_bad;
                    end
                end
            end

            S_FILL: begin
                // waddr_reg is the address being written this cycle.
                if (waddr_reg == {ADDR_W{1'b1}}) begin
                    state_next    = S_DONE;
                    done_next     = 1'b1;
                    cpu_hold_next = err_reg;
                end else begin
                    we_next    = 1'b1;
                    waddr_next = waddr_reg + ADDR_W'(1);
                end
            end

            S_DONE: begin
                if (bus.start) begin
                    state_next    = S_COUNT;
                    done_next     = 1'b0;
                    err_next      = 1'b0;
                    cpu_hold_next = 1'b1;
                    byte_idx_next = '0;
                    word_idx_next = '0;
                    csum_next     = '0;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.byte_ready = byte_ready_int;
    assign bus.we         = we_reg;
    assign bus.waddr      = waddr_reg;
    assign bus.wdata      = wdata_reg;
    assign bus.cpu_hold   = cpu_hold_reg;
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Scoreboard bench for imem_loader: each load computes the expected imem
// writes and final status from the byte stream; a monitor pops and compares
// every write the loader issues.
module tb_imem_loader;
    typedef logic [7:0] u8_t;

    logic clk;
    logic reset;

    imem_loader_if #(.N(32), .ADDR_W(6)) bus ();

    imem_loader #(.N(32), .ADDR_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    u8_t         stim_q[$];
    logic [37:0] exp_q[$];   // {addr, data}

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Write monitor: every write must be the next expected one, and the core
    // must be held while memory is being written.
    always @(negedge clk) begin
        logic [37:0] e;
        if (reset === 1'b1 && bus.we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h", bus.waddr, bus.wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.waddr, bus.wdata} !== e) begin
                    failures++;
                    $display("FAIL write actual=@%0d:%h required=@%0d:%h",
                             bus.waddr, bus.wdata, e[37:32], e[31:0]);
                end else begin
                    $display("write @%0d = %h", bus.waddr, bus.wdata);
                end
            end
            chk("cpu_hold_during_write", 64'(bus.cpu_hold), 64'd1);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Reference model: words from the payload at 0..C-1, zeros at C..63,
    // error when C>64 (nothing written) or the XOR checksum disagrees.
    task automatic build_expect(output bit exp_err, output bit bad_count);
        int          c;
        logic [7:0]  x;
        logic [31:0] w;
        c = int'(stim_q[0]);
        x = 8'h00;
        bad_count = 1'b0;
        exp_err = 1'b0;
        if (c > 64) begin
            bad_count = 1'b1;
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < c; i++) begin
            w = {stim_q[1+4*i+3], stim_q[1+4*i+2], stim_q[1+4*i+1], stim_q[1+4*i]};
            x = x ^ stim_q[1+4*i] ^ stim_q[1+4*i+1] ^ stim_q[1+4*i+2] ^ stim_q[1+4*i+3];
            exp_q.push_back({6'(i), w});
        end
        for (int a = c; a < 64; a++) exp_q.push_back({6'(a), 32'h0});
        exp_err = (stim_q[1+4*c] != x);
    endtask

    // Entered and left on a negedge; returns at the negedge right after the
    // edge on which the byte transferred.
    task automatic send_byte(input u8_t b, input bit gaps);
        int tries;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        tries = 0;
        while (bus.byte_ready !== 1'b1 && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 100) begin
            checks++;
            failures++;
            $display("FAIL byte_ready_timeout actual=0 required=1");
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
        chk("rst_we",         64'(bus.we),         64'd0);
        chk("rst_waddr",      64'(bus.waddr),      64'd0);
        chk("rst_wdata",      64'(bus.wdata),      64'd0);
        chk("rst_cpu_hold",   64'(bus.cpu_hold),   64'd1);
        chk("rst_done",       64'(bus.done),       64'd0);
        chk("rst_err",        64'(bus.err),        64'd0);
    endtask

    task automatic run_load(input string name, input bit gaps);
        bit exp_err;
        bit bad_count;
        int c;
        int t;
        build_expect(exp_err, bad_count);
        c = int'(stim_q[0]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ready_after_start", 64'(bus.byte_ready), 64'd1);
        for (int i = 0; i < stim_q.size(); i++) begin
            send_byte(stim_q[i], gaps);
            if (i == 0 && bad_count) begin
                chk("bad_count_done",  64'(bus.done),       64'd1);
                chk("bad_count_err",   64'(bus.err),        64'd1);
                chk("bad_count_ready", 64'(bus.byte_ready), 64'd0);
                break;
            end
        end
        if (!bad_count) begin
            if (c == 64) begin
                chk("done_after_csum", 64'(bus.done), 64'd1);
            end else begin
                chk("fill_start", {62'(bus.waddr), bus.we, bus.done}, {62'(c), 1'b1, 1'b0});
            end
        end
        t = 0;
        while (bus.done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("done",           64'(bus.done),     64'd1);
        chk("err",            64'(bus.err),      64'(exp_err));
        chk("cpu_hold",       64'(bus.cpu_hold), 64'(exp_err));
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        chk("we_idle",        64'(bus.we),       64'd0);
        $display("load %s C=%0d done=%0d err=%0d cpu_hold=%0d",
                 name, c, bus.done, bus.err, bus.cpu_hold);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic make_random(input int c, input bit corrupt);
        u8_t x;
        u8_t b;
        stim_q.delete();
        stim_q.push_back(8'(c));
        x = 8'h00;
        repeat (4 * c) begin
            b = 8'($urandom);
            x = x ^ b;
            stim_q.push_back(b);
        end
        if (corrupt) x = x ^ 8'(1 << $urandom_range(0, 7));
        stim_q.push_back(x);
    endtask

    initial begin
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        @(negedge clk);

        stim_q = {8'h02, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h1F, 8'h00, 8'h00, 8'hB4, 8'h52};
        run_load("clean_c2", 1'b0);

        stim_q = {8'h02, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h1F, 8'h00, 8'h00, 8'hB4, 8'h53};
        run_load("bad_csum", 1'b0);

        stim_q = {8'h41};
        run_load("bad_count", 1'b0);

        stim_q = {8'h00, 8'h00};
        run_load("empty", 1'b0);

        // Reset after two payload bytes of word 0: nothing may be written.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        @(negedge clk);
        $display("reset mid-word applied");

        stim_q = {8'h02, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h1F, 8'h00, 8'h00, 8'hB4, 8'h52};
        run_load("clean_after_reset", 1'b0);

        make_random(64, 1'b0);
        run_load("full_backpressure", 1'b1);

        for (int k = 0; k < 3; k++) begin
            make_random($urandom_range(1, 63), 1'($urandom_range(0, 1)));
            run_load("random", 1'b1);
        end

        make_random(63, 1'b0);
        run_load("c63", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
